pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Parametrised pipeline control unit for the RV32 core: merges load-use, multi-cycle M-type
//   (mul/div), branch-redirect and external memory-wait requests into per-stage stall/flush vectors.
//   Sits beside the forwarding unit. Drives pc_reg, if_id, id_exe, exe_mem and mem_wb.
//   Stage index: bit0=PC, bit1=IF/ID, bit2=ID/EXE, bit3=EXE/MEM, bit4=MEM/WB.
// PARAMETERS
//   NSTAGES        5   width of stall_o/flush_o (pipeline register count incl. PC)
//   MDIV_CYCLES    34  total cycles an M-type instruction occupies EXE (>=1)
//   BR_FLUSH_DEPTH 2   redirect flushes stages 1..BR_FLUSH_DEPTH (1..NSTAGES-1)
//   CNT_W          6   down-counter width; must satisfy 2**CNT_W > MDIV_CYCLES
// PORTS
//   clk_i            in   1        clock
//   rst_i            in   1        synchronous reset, active-high
//   load_hazard_i    in   1        load-use hazard from forwarding unit
//   m_req_i          in   1        level: M-type instruction present in EXE
//   redirect_i       in   1        branch/jump taken in EXE, wrong-path fetch in IF/ID
//   ext_stall_i      in   1        memory not ready; freeze whole pipe
//   stall_o          out  NSTAGES  per-stage hold
//   flush_o          out  NSTAGES  per-stage bubble insert
//   mdiv_last_o      out  1        final EXE cycle of M-type; EXE latches result
//   busy_o           out  1        FSM in BUSY
//   stall_cnt_o      out  32       perf: cycles with stall_o[0]=1   (see CONFIGURATION)
//   flush_cnt_o      out  32       perf: cycles with any flush_o bit set
// BEHAVIOUR
//   - Outputs combinational from state + inputs (0-cycle latency); FSM state and counter registered.
//   - stall_o is always a prefix: stall_o[k]=1 implies stall_o[j]=1 for all j<k.
//   - rst_i=1: state<=IDLE, cnt<=0, perf counters<=0; during reset stall_o=0,
//     flush_o={NSTAGES{1}}, mdiv_last_o=0, busy_o=0. Reset mid-BUSY aborts to IDLE.
//   - FSM IDLE / BUSY. Priority per cycle: rst_i > ext_stall_i > BUSY > redirect_i > m_req_i > load_hazard_i.
//   - ext_stall_i=1: stall_o=all ones, flush_o=0, state and cnt hold, no transition, mdiv_last_o=0.
//   - IDLE, m_req_i, MDIV_CYCLES>1: stall_o[2:0]=1, flush_o[3]=1, cnt<=MDIV_CYCLES-2, ->BUSY.
//   - IDLE, m_req_i, MDIV_CYCLES==1: no stall, mdiv_last_o=1, stay IDLE.
//   - BUSY, cnt!=0: stall_o[2:0]=1, flush_o[3]=1, cnt<=cnt-1.
//   - BUSY, cnt==0: stall_o=0, flush_o=0, mdiv_last_o=1, ->IDLE (instruction advances next edge).
//     EXE occupancy = exactly MDIV_CYCLES cycles; stall held MDIV_CYCLES-1 cycles.
//   - BUSY: redirect_i, load_hazard_i, m_req_i ignored (bench asserts redirect_i never set in BUSY).
//   - IDLE, redirect_i: flush_o[BR_FLUSH_DEPTH:1]=1, stall_o=0; same-cycle load_hazard_i dropped
//     (consumer is wrong-path). redirect_i with m_req_i: redirect wins, m_req_i retried next cycle.
//   - IDLE, load_hazard_i only: stall_o[1:0]=1, flush_o[2]=1 for that cycle; one bubble per assertion.
//   - Back-to-back M-type: m_req_i high the cycle after ->IDLE starts a new sequence immediately.
//   - No inputs active: stall_o=0, flush_o=0.
// CONFIGURATION
//   PIPE_HAZARD_CTRL_PERF_EN defined: stall_cnt_o/flush_cnt_o are 32-bit free-running counters,
//     incremented on edges where the condition holds and rst_i=0; wrap 0xFFFFFFFF->0.
//   Not defined: no counter registers; stall_cnt_o and flush_cnt_o tied to 0.
// TESTING
//   1 rst_i=1 two cycles -> stall_o=5'b00000, flush_o=5'b11111, busy_o=0; release -> both 0.
//   2 load_hazard_i one cycle -> stall_o=5'b00011, flush_o=5'b00100 that cycle only; next cycle 0.
//   3 MDIV_CYCLES=34, m_req_i held -> stall_o=5'b00111 for 33 cycles, mdiv_last_o=1 on cycle 34
//     with stall_o=0; ext_stall_i pulsed 3 cycles mid-sequence -> total extends to 37 cycles.
//   4 redirect_i + load_hazard_i same cycle -> flush_o=5'b00110, stall_o=0.
//   5 rst_i at BUSY cnt=10 -> next cycle busy_o=0, stall_o=0; m_req_i then restarts full 34-cycle run.
//   6 PERF_EN: 100 idle + 1 load-use + one M-type -> stall_cnt_o=34, flush_cnt_o=34;
//     without macro both read 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: merges load-use, M-type, redirect and memory-wait requests into stall/flush vectors.
// Optional perf counters are built when PIPE_HAZARD_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int NSTAGES        = 5,
  parameter int MDIV_CYCLES    = 34,
  parameter int BR_FLUSH_DEPTH = 2,
  parameter int CNT_W          = 6
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_hazard_i,
  input  logic               m_req_i,
  input  logic               redirect_i,
  input  logic               ext_stall_i,
  output logic [NSTAGES-1:0] stall_o,
  output logic [NSTAGES-1:0] flush_o,
  output logic               mdiv_last_o,
  output logic               busy_o,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        flush_cnt_o
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [NSTAGES-1:0] MdStall  = NSTAGES'(7);
  localparam logic [NSTAGES-1:0] MdFlush  = NSTAGES'(8);
  localparam logic [NSTAGES-1:0] LuStall  = NSTAGES'(3);
  localparam logic [NSTAGES-1:0] LuFlush  = NSTAGES'(4);
  localparam logic [NSTAGES-1:0] BrFlush  = NSTAGES'((1 << (BR_FLUSH_DEPTH + 1)) - 2);
  localparam logic [CNT_W-1:0]   CntLoad  = CNT_W'((MDIV_CYCLES > 1) ? (MDIV_CYCLES - 2) : 0);
  localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request priority: reset, memory wait, in-flight M-type, redirect, new M-type, load-use.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_o     = '0;
    flush_o     = '0;
    mdiv_last_o = 1'b0;
    busy_o      = (state_q == BUSY);
    if (rst_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      flush_o = '1;
      busy_o  = 1'b0;
    end else if (ext_stall_i) begin
      stall_o = '1;
    end else if (state_q == BUSY) begin
      if (cnt_q != '0) begin
        stall_o = MdStall;
        flush_o = MdFlush;
        cnt_d   = cnt_q - CntOne;
      end else begin
        mdiv_last_o = 1'b1;
        state_d     = IDLE;
      end
    end else if (redirect_i) begin
      flush_o = BrFlush;
    end else if (m_req_i) begin
      if (MDIV_CYCLES > 1) begin
        stall_o = MdStall;
        flush_o = MdFlush;
        cnt_d   = CntLoad;
        state_d = BUSY;
      end else begin
        mdiv_last_o = 1'b1;
      end
    end else if (load_hazard_i) begin
      stall_o = LuStall;
      flush_o = LuFlush;
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stallCnt_q, flushCnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      if (stall_o[0]) stallCnt_q <= stallCnt_q + 32'd1;
      if (|flush_o)   flushCnt_q <= flushCnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: reset, load-use, M-type runs with memory wait, redirect, abort, perf counters.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst, loadHazard, mReq, redirect, extStall;
  logic [4:0]  stall, flush;
  logic        mdivLast, busy;
  logic [31:0] stallCnt, flushCnt;
  int          vectorCount = 0;
  int          missCount   = 0;

  pipe_hazard_ctrl dut (
    .clk_i(clk), .rst_i(rst), .load_hazard_i(loadHazard), .m_req_i(mReq),
    .redirect_i(redirect), .ext_stall_i(extStall), .stall_o(stall), .flush_o(flush),
    .mdiv_last_o(mdivLast), .busy_o(busy), .stall_cnt_o(stallCnt), .flush_cnt_o(flushCnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked 1 unit later.
  task automatic applyStimulus(input logic r, input logic lh, input logic mr, input logic rd, input logic es);
    rst = r; loadHazard = lh; mReq = mr; redirect = rd; extStall = es;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVec(input string tag, input logic [4:0] s, input logic [4:0] f, input logic ml, input logic b);
    checkOutput({tag, ".stall"}, 32'(stall), 32'(s));
    checkOutput({tag, ".flush"}, 32'(flush), 32'(f));
    checkOutput({tag, ".mdivLast"}, 32'(mdivLast), 32'(ml));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(b));
  endtask

  initial begin
    int extK;
    logic [4:0] expS, expF;
    logic expMl, expB;
    string tag;
    rst = 1'b1; loadHazard = 1'b0; mReq = 1'b0; redirect = 1'b0; extStall = 1'b0;
    #1;

    applyStimulus(1, 0, 0, 0, 0);
    checkVec("reset0", 5'b00000, 5'b11111, 0, 0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0);
    checkVec("reset1", 5'b00000, 5'b11111, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0);
    checkVec("released", 5'b00000, 5'b00000, 0, 0);
    nextCycle();

    applyStimulus(0, 1, 0, 0, 0);
    checkVec("loaduse", 5'b00011, 5'b00100, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0);
    checkVec("loaduseAfter", 5'b00000, 5'b00000, 0, 0);
    nextCycle();

    applyStimulus(0, 1, 1, 0, 1);
    checkVec("extIdle", 5'b11111, 5'b00000, 0, 0);
    nextCycle();

    // Plain 34-cycle M-type run, m_req held throughout.
    for (int k = 1; k <= 34; k++) begin
      applyStimulus(0, 0, 1, 0, 0);
      tag = $sformatf("mdiv%0d", k);
      if (k < 34) checkVec(tag, 5'b00111, 5'b01000, 0, (k > 1));
      else        checkVec(tag, 5'b00000, 5'b00000, 1, 1);
      nextCycle();
    end

    // Back-to-back run starting immediately, memory wait on cycles 10..12 stretches it to 37.
    for (int k = 1; k <= 37; k++) begin
      extK = (k >= 10 && k <= 12) ? 1 : 0;
      applyStimulus(0, 0, 1, 0, extK[0]);
      expB  = (k > 1);
      expMl = 1'b0;
      if (extK == 1)   begin expS = 5'b11111; expF = 5'b00000; end
      else if (k < 37) begin expS = 5'b00111; expF = 5'b01000; end
      else             begin expS = 5'b00000; expF = 5'b00000; expMl = 1'b1; end
      checkVec($sformatf("mdivExt%0d", k), expS, expF, expMl, expB);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkVec("mdivExtDone", 5'b00000, 5'b00000, 0, 0);
    nextCycle();

    applyStimulus(0, 1, 0, 1, 0);
    checkVec("redirLoad", 5'b00000, 5'b00110, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 1, 1, 0);
    checkVec("redirMreq", 5'b00000, 5'b00110, 0, 0);
    nextCycle();

    // Retried M-type, aborted by reset once the counter reaches 10 (cycle 24).
    for (int k = 1; k <= 23; k++) begin
      applyStimulus(0, 0, 1, 0, 0);
      checkVec($sformatf("abortRun%0d", k), 5'b00111, 5'b01000, 0, (k > 1));
      nextCycle();
    end
    applyStimulus(1, 0, 1, 0, 0);
    checkVec("abortRst", 5'b00000, 5'b11111, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0);
    checkVec("abortAfter", 5'b00000, 5'b00000, 0, 0);
    nextCycle();
    for (int k = 1; k <= 34; k++) begin
      applyStimulus(0, 0, 1, 0, 0);
      if (k < 34) checkVec($sformatf("restart%0d", k), 5'b00111, 5'b01000, 0, (k > 1));
      else        checkVec("restartLast", 5'b00000, 5'b00000, 1, 1);
      nextCycle();
    end

    // Performance counters from a clean reset.
    applyStimulus(1, 0, 0, 0, 0);
    nextCycle();
    for (int k = 0; k < 100; k++) begin
      applyStimulus(0, 0, 0, 0, 0);
      nextCycle();
    end
    checkOutput("perfIdleStall", stallCnt, 32'd0);
    checkOutput("perfIdleFlush", flushCnt, 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    nextCycle();
    for (int k = 1; k <= 34; k++) begin
      applyStimulus(0, 0, 1, 0, 0);
      nextCycle();
    end
    applyStimulus(0, 0, 0, 0, 0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    checkOutput("perfStallCnt", stallCnt, 32'd34);
    checkOutput("perfFlushCnt", flushCnt, 32'd34);
`else
    checkOutput("perfStallCnt", stallCnt, 32'd0);
    checkOutput("perfFlushCnt", flushCnt, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
